// File: rtl/plumbing_pkg.sv
// Shared constants and helpers for the lane plumbing blocks
// (round-robin dispatcher and address-driven demultiplexor).
package plumbing_pkg;

    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 2;

    function automatic int unsigned lanes(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/rr_dispatcher_pick.sv
// Round-robin lane picker: rotate enables to the start pointer,
// take the lowest set bit, then map the offset back to a lane index.
module rr_pick
    import plumbing_pkg::*;
#(
    parameter  int unsigned W = DEFAULT_ADDRESS_WIDTH,
    localparam int unsigned N = lanes(W)
) (
    input  logic [N-1:0] en,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;

    always_comb begin
        dbl   = {en, en};
        rot   = dbl[start +: N];
        found = |rot;
        off   = '0;
        // Descending scan so the lowest set offset wins
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = W'(i);
        end
        idx = off + start;
    end

endmodule

// File: rtl/rr_dispatcher.sv
// Registered round-robin / direct lane dispatcher feeding the
// demultiplexor address and data inputs through one output register.
module rr_dispatcher
    import plumbing_pkg::*;
#(
    parameter  int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    localparam int unsigned LANES         = lanes(ADDRESS_WIDTH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic                     i_x,
    input  logic                     i_direct,
    input  logic [ADDRESS_WIDTH-1:0] i_dest,
    output logic                     o_ready,
    input  logic [LANES-1:0]         i_lane_enable,
    input  logic [LANES-1:0]         i_lane_ready,
    output logic                     o_valid,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic                     o_x
);

    logic [ADDRESS_WIDTH-1:0] ptr;
    logic [ADDRESS_WIDTH-1:0] rr_idx;
    logic                     rr_found;
    logic [ADDRESS_WIDTH-1:0] sel;
    logic                     sel_ok;
    logic                     out_fire;
    logic                     in_fire;

    rr_pick #(
        .W(ADDRESS_WIDTH)
    ) u_pick (
        .en   (i_lane_enable),
        .start(ptr),
        .idx  (rr_idx),
        .found(rr_found)
    );

    always_comb begin
        sel    = rr_idx;
        sel_ok = rr_found;
        if (i_direct) begin
            sel    = i_dest;
            sel_ok = i_lane_enable[i_dest];
        end
    end

    assign out_fire = o_valid & i_lane_ready[o_address];
    // Held low through reset so upstream never sees a phantom accept
    assign o_ready  = i_rst_n & sel_ok & (~o_valid | out_fire);
    assign in_fire  = i_valid & o_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_address <= '0;
            o_x       <= 1'b0;
            ptr       <= '0;
        end else begin
            if (in_fire) begin
                o_valid   <= 1'b1;
                o_address <= sel;
                o_x       <= i_x;
            end else if (out_fire) begin
                o_valid   <= 1'b0;
            end
            if (in_fire && !i_direct) begin
                ptr <= sel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Scenario bench for rr_dispatcher with an expected-output queue.
module tb_rr_dispatcher;

    logic       clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       i_x;
    logic       i_direct;
    logic [1:0] i_dest;
    logic       o_ready;
    logic [3:0] i_lane_enable;
    logic [3:0] i_lane_ready;
    logic       o_valid;
    logic [1:0] o_address;
    logic       o_x;

    typedef struct packed {
        logic [1:0] a;
        logic       x;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks;
    int   failures;

    rr_dispatcher #(
        .ADDRESS_WIDTH(2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_x          (i_x),
        .i_direct     (i_direct),
        .i_dest       (i_dest),
        .o_ready      (o_ready),
        .i_lane_enable(i_lane_enable),
        .i_lane_ready (i_lane_ready),
        .o_valid      (o_valid),
        .o_address    (o_address),
        .o_x          (o_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_reset();
        i_rst_n       = 1'b0;
        i_valid       = 1'b1;
        i_x           = 1'b1;
        i_direct      = 1'b0;
        i_dest        = 2'd0;
        i_lane_enable = 4'b1111;
        i_lane_ready  = 4'b1111;
        tick();
        tick();
        checks++;
        if ({o_valid, o_address, o_x} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0000",
                     {o_valid, o_address, o_x});
        end
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", o_ready);
        end
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_rr_all();
        logic [1:0] ea[6];
        ea = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        i_lane_enable = 4'b1111;
        i_lane_ready  = 4'b1111;
        i_direct      = 1'b0;
        i_valid       = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_x = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (o_ready !== 1'b1) begin
                failures++;
                $display("FAIL rr_all_ready[%0d] got=%b exp=1", i, o_ready);
            end
            q.push_back('{a: ea[i], x: i_x});
            tick();
            e = q.pop_front();
            checks++;
            if ({o_valid, o_address, o_x} !== {1'b1, e.a, e.x}) begin
                failures++;
                $display("FAIL rr_all_out[%0d] got=%b exp=%b", i,
                         {o_valid, o_address, o_x}, {1'b1, e.a, e.x});
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_rr_enables();
        logic [1:0] ea[4];
        ea = '{2'd1, 2'd3, 2'd1, 2'd3};
        do_reset();
        i_lane_enable = 4'b1010;
        i_lane_ready  = 4'b1111;
        i_valid       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_x = i[0];
            #1;
            q.push_back('{a: ea[i], x: i_x});
            tick();
            e = q.pop_front();
            checks++;
            if ({o_valid, o_address, o_x} !== {1'b1, e.a, e.x}) begin
                failures++;
                $display("FAIL rr_en_out[%0d] got=%b exp=%b", i,
                         {o_valid, o_address, o_x}, {1'b1, e.a, e.x});
            end
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_en_drain got=%b exp=0", o_valid);
        end
    endtask

    task automatic test_hold();
        // ptr is 0 here
        i_lane_enable = 4'b0100;
        i_lane_ready  = 4'b1011;
        i_valid       = 1'b1;
        i_x           = 1'b1;
        q.push_back('{a: 2'd2, x: 1'b1});
        tick();
        i_x = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_lane_enable = (i == 1) ? 4'b0001 : 4'b1111;
            #1;
            checks++;
            if (o_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_ready[%0d] got=%b exp=0", i, o_ready);
            end
            checks++;
            if ({o_valid, o_address, o_x} !== {1'b1, q[0].a, q[0].x}) begin
                failures++;
                $display("FAIL hold_out[%0d] got=%b exp=%b", i,
                         {o_valid, o_address, o_x}, {1'b1, q[0].a, q[0].x});
            end
            tick();
        end
        i_lane_enable = 4'b1111;
        i_lane_ready  = 4'b1111;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release_ready got=%b exp=1", o_ready);
        end
        void'(q.pop_front());
        q.push_back('{a: 2'd3, x: 1'b0});
        tick();
        e = q.pop_front();
        checks++;
        if ({o_valid, o_address, o_x} !== {1'b1, e.a, e.x}) begin
            failures++;
            $display("FAIL hold_next got=%b exp=%b",
                     {o_valid, o_address, o_x}, {1'b1, e.a, e.x});
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_no_enable();
        // ptr is 0 here
        i_lane_enable = 4'b0000;
        i_valid       = 1'b1;
        i_x           = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (o_ready !== 1'b0) begin
                failures++;
                $display("FAIL noen_ready[%0d] got=%b exp=0", i, o_ready);
            end
            tick();
            checks++;
            if (o_valid !== 1'b0) begin
                failures++;
                $display("FAIL noen_valid[%0d] got=%b exp=0", i, o_valid);
            end
        end
        i_lane_enable = 4'b0100;
        q.push_back('{a: 2'd2, x: 1'b1});
        tick();
        e = q.pop_front();
        checks++;
        if ({o_valid, o_address, o_x} !== {1'b1, e.a, e.x}) begin
            failures++;
            $display("FAIL noen_lane2 got=%b exp=%b",
                     {o_valid, o_address, o_x}, {1'b1, e.a, e.x});
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_direct();
        // ptr is 3 here
        logic [1:0] ed[3];
        ed = '{2'd3, 2'd0, 2'd3};
        i_lane_enable = 4'b1111;
        i_lane_ready  = 4'b1111;
        i_valid       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_direct = (i < 2);
            i_dest   = (i == 0) ? 2'd3 : 2'd0;
            i_x      = (i != 1);
            #1;
            q.push_back('{a: ed[i], x: i_x});
            tick();
            e = q.pop_front();
            checks++;
            if ({o_valid, o_address, o_x} !== {1'b1, e.a, e.x}) begin
                failures++;
                $display("FAIL direct_out[%0d] got=%b exp=%b", i,
                         {o_valid, o_address, o_x}, {1'b1, e.a, e.x});
            end
        end
        i_direct      = 1'b1;
        i_dest        = 2'd3;
        i_lane_enable = 4'b0111;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL direct_stall_ready got=%b exp=0", o_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL direct_stall_valid got=%b exp=0", o_valid);
        end
        i_direct = 1'b0;
        i_valid  = 1'b0;
        tick();
    endtask

    task automatic test_reset_hold();
        i_lane_enable = 4'b0010;
        i_lane_ready  = 4'b0000;
        i_valid       = 1'b1;
        i_x           = 1'b1;
        tick();
        checks++;
        if ({o_valid, o_address, o_x} !== 4'b1011) begin
            failures++;
            $display("FAIL rsthold_load got=%b exp=1011",
                     {o_valid, o_address, o_x});
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            failures++;
            $display("FAIL rsthold_ready got=%b exp=0", o_ready);
        end
        tick();
        checks++;
        if ({o_valid, o_address, o_x} !== 4'b0000) begin
            failures++;
            $display("FAIL rsthold_clear got=%b exp=0000",
                     {o_valid, o_address, o_x});
        end
        q.delete();
        i_rst_n       = 1'b1;
        i_lane_enable = 4'b1111;
        i_lane_ready  = 4'b1111;
        i_x           = 1'b1;
        q.push_back('{a: 2'd0, x: 1'b1});
        tick();
        e = q.pop_front();
        checks++;
        if ({o_valid, o_address, o_x} !== {1'b1, e.a, e.x}) begin
            failures++;
            $display("FAIL rsthold_first got=%b exp=%b",
                     {o_valid, o_address, o_x}, {1'b1, e.a, e.x});
        end
        i_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_rr_all();
        test_rr_enables();
        test_hold();
        test_no_enable();
        test_direct();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
